// File: rtl/rle_serial_decoder.sv
// Serial RLE run decoder: 8N1 receiver feeding a byte FIFO, drained by a
// pixel emitter that replays each run over the dav_/rfd producer handshake.
module rle_serial_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic rxd,
  output logic colore,
  output logic endline,
  output logic dav_,
  input  logic rfd,
  output logic overrun,
  output logic frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_DATA   = 2'd1;
  localparam logic [1:0] R_STOP   = 2'd2;
  localparam logic [1:0] R_RESYNC = 2'd3;

  localparam logic [1:0] E_IDLE  = 2'd0;
  localparam logic [1:0] E_SETUP = 2'd1;
  localparam logic [1:0] E_ACK   = 2'd2;
  localparam logic [1:0] E_REL   = 2'd3;

  logic [1:0]    rstate_q, rstate_d;
  logic [2:0]    bitk_q, bitk_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    estate_q, estate_d;
  logic [6:0]    remaining_q, remaining_d;
  logic          colore_q, colore_d;
  logic          endline_q, endline_d;
  logic          dav_q, dav_d;
  logic          overrun_q, frame_err_q;

  logic       push, pop, accept, full;
  logic [7:0] head;

  assign full   = (cnt_q == FULL);
  assign push   = (rstate_q == R_STOP) && rxd;
  assign pop    = (estate_q == E_IDLE) && (cnt_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign accept = push && (!full || pop);
  assign head   = mem_q[rptr_q];

  always_comb begin
    rstate_d = rstate_q;
    bitk_d   = bitk_q;
    shift_d  = shift_q;
    case (rstate_q)
      R_IDLE: if (!rxd) begin
        rstate_d = R_DATA;
        bitk_d   = '0;
      end
      R_DATA: begin
        shift_d[bitk_q] = rxd;
        bitk_d          = bitk_q + 3'd1;
        if (bitk_q == 3'd7) rstate_d = R_STOP;
      end
      R_STOP:   rstate_d = rxd ? R_IDLE : R_RESYNC;
      R_RESYNC: if (rxd) rstate_d = R_IDLE;
      default:  rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    estate_d    = estate_q;
    remaining_d = remaining_q;
    colore_d    = colore_q;
    endline_d   = endline_q;
    dav_d       = dav_q;
    case (estate_q)
      E_IDLE: if (pop) begin
        estate_d = E_SETUP;
        // A zero count is a single end-of-line token regardless of colour bit.
        if (head[7:1] == 7'd0) begin
          remaining_d = 7'd1;
          endline_d   = 1'b1;
          colore_d    = 1'b0;
        end else begin
          remaining_d = head[7:1];
          endline_d   = 1'b0;
          colore_d    = head[0];
        end
      end
      E_SETUP: if (rfd) begin
        estate_d = E_ACK;
        dav_d    = 1'b0;
      end
      E_ACK: if (!rfd) begin
        estate_d = E_REL;
        dav_d    = 1'b1;
      end
      E_REL: if (rfd) begin
        remaining_d = remaining_q - 7'd1;
        estate_d    = (remaining_q == 7'd1) ? E_IDLE : E_SETUP;
      end
      default: estate_d = E_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (accept) mem_q[wptr_q] <= shift_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rstate_q    <= R_IDLE;
      bitk_q      <= '0;
      shift_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      estate_q    <= E_IDLE;
      remaining_q <= '0;
      colore_q    <= 1'b0;
      endline_q   <= 1'b0;
      dav_q       <= 1'b1;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rstate_q    <= rstate_d;
      bitk_q      <= bitk_d;
      shift_q     <= shift_d;
      if (accept) wptr_q <= wptr_q + AW'(1);
      if (pop)    rptr_q <= rptr_q + AW'(1);
      cnt_q       <= cnt_d;
      estate_q    <= estate_d;
      remaining_q <= remaining_d;
      colore_q    <= colore_d;
      endline_q   <= endline_d;
      dav_q       <= dav_d;
      overrun_q   <= push && full && !pop;
      frame_err_q <= (rstate_q == R_STOP) && !rxd;
    end
  end

  assign colore    = colore_q;
  assign endline   = endline_q;
  assign dav_      = dav_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rle_serial_decoder.sv
// Bench for rle_serial_decoder: frames driven on rxd, expected token stream
// built from the byte values, compared at every dav_ falling edge.
module tb_rle_serial_decoder;
  localparam int FD = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rxd   = 1'b1;
  logic rfd   = 1'b0;
  logic colore, endline, dav_, overrun, frame_err;

  rle_serial_decoder #(.FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset(reset), .rxd(rxd), .colore(colore),
    .endline(endline), .dav_(dav_), .rfd(rfd), .overrun(overrun),
    .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic endl; logic col; } tok_t;
  tok_t exp_q[$];
  tok_t cur;
  logic cur_valid = 1'b0;
  logic prev_dav  = 1'b1;
  int errs = 0, checks = 0;
  int hs_cnt = 0, ov_cnt = 0, fe_cnt = 0;
  int cmode = 2; // 0: stall rfd low, 1: random consumer, 2: rfd stuck high

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Expected pixel tokens for one decoded byte.
  function automatic void expand(logic [7:0] b);
    tok_t t;
    if (b[7:1] == 7'd0) begin
      t.endl = 1'b1; t.col = 1'b0;
      exp_q.push_back(t);
    end else begin
      for (int i = 0; i < int'(b[7:1]); i++) begin
        t.endl = 1'b0; t.col = b[0];
        exp_q.push_back(t);
      end
    end
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      prev_dav  = 1'b1;
      cur_valid = 1'b0;
    end else begin
      if (prev_dav && !dav_) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_token", 1, 0);
          cur_valid = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          cur_valid = 1'b1;
          check("tok_colore", colore, cur.col);
          check("tok_endline", endline, cur.endl);
        end
      end else if (!dav_ && cur_valid) begin
        check("hold_colore", colore, cur.col);
        check("hold_endline", endline, cur.endl);
      end
      if (overrun)   ov_cnt++;
      if (frame_err) fe_cnt++;
      prev_dav = dav_;
    end
  end

  always @(posedge clock) begin
    #1;
    case (cmode)
      0: rfd = 1'b0;
      2: rfd = 1'b1;
      default: begin
        if (!dav_ && rfd && $urandom_range(0, 1) == 0) rfd = 1'b0;
        else if (dav_ && !rfd && $urandom_range(0, 1) == 0) rfd = 1'b1;
      end
    endcase
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send_frame(logic [7:0] b, logic stopb);
    rxd = 1'b0; tick();
    for (int i = 0; i < 8; i++) begin rxd = b[i]; tick(); end
    rxd = stopb; tick();
  endtask

  task automatic wait_tokens(string name, int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin tick(); n++; end
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    n = 0;
    while (!(dav_ && rfd) && n < 200) begin tick(); n++; end
    tick(2);
  endtask

  initial begin #2000000; $display("FAIL watchdog: simulation timed out"); $fatal; end

  initial begin
    int hsb, ovb, feb, n, acc, eov, efe;
    logic [7:0] b;
    logic [7:0] t5 [6];
    bit stall, bad;

    // 1: reset and idle line
    tick(); reset = 1'b0;
    check("rst_dav", dav_, 1); check("rst_colore", colore, 0);
    check("rst_endline", endline, 0); check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    tick(20);
    check("t1_hs", hs_cnt, 0); check("t1_ov", ov_cnt, 0);
    check("t1_fe", fe_cnt, 0); check("t1_dav", dav_, 1);

    // 2: one run of 30 black pixels
    cmode = 1; hsb = hs_cnt;
    expand(8'h3D);
    check("t2_model_len", exp_q.size(), 30);
    send_frame(8'h3D, 1'b1);
    wait_tokens("t2", 2000);
    tick(10);
    check("t2_hs", hs_cnt - hsb, 30); check("t2_dav_idle", dav_, 1);

    // 3: back-to-back end-of-line tokens
    hsb = hs_cnt;
    expand(8'h00); expand(8'h01);
    check("t3_model_endl", exp_q[1].endl, 1);
    send_frame(8'h00, 1'b1); send_frame(8'h01, 1'b1);
    wait_tokens("t3", 500);
    check("t3_hs", hs_cnt - hsb, 2);

    // 4: framing error then resync
    hsb = hs_cnt; feb = fe_cnt;
    send_frame(8'hFF, 1'b0);
    rxd = 1'b0; tick(3); rxd = 1'b1; tick();
    expand(8'h04);
    send_frame(8'h04, 1'b1);
    wait_tokens("t4", 500);
    check("t4_fe", fe_cnt - feb, 1); check("t4_hs", hs_cnt - hsb, 2);

    // 5: stalled consumer, FIFO overflow on the sixth byte
    cmode = 0; tick(2);
    hsb = hs_cnt; ovb = ov_cnt;
    t5[0] = 8'h03; t5[1] = 8'h05; t5[2] = 8'h07;
    t5[3] = 8'h09; t5[4] = 8'h0B; t5[5] = 8'h0D;
    for (int i = 0; i < 5; i++) expand(t5[i]);
    for (int i = 0; i < 6; i++) send_frame(t5[i], 1'b1);
    tick(3);
    check("t5_ov", ov_cnt - ovb, 1); check("t5_stalled", hs_cnt - hsb, 0);
    cmode = 1;
    wait_tokens("t5", 1000);
    check("t5_hs", hs_cnt - hsb, 15);

    // 6: reset in the middle of a handshake and of a frame
    cmode = 2; tick(2); hsb = hs_cnt;
    expand(8'h15);
    send_frame(8'h15, 1'b1);
    n = 0;
    while (dav_ && n < 20) begin tick(); n++; end
    check("t6_in_ack", dav_, 0);
    b = 8'h7F;
    rxd = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin rxd = b[i]; tick(); end
    reset = 1'b1; tick(); reset = 1'b0; rxd = 1'b1;
    exp_q.delete();
    check("t6_dav", dav_, 1); check("t6_colore", colore, 0);
    check("t6_endline", endline, 0);
    tick(30);
    check("t6_no_more", hs_cnt - hsb, 1);
    cmode = 1;
    expand(8'h02);
    send_frame(8'h02, 1'b1);
    wait_tokens("t6", 500);
    check("t6_hs", hs_cnt - hsb, 2);

    // 7: longest run
    hsb = hs_cnt;
    expand(8'hFF);
    send_frame(8'hFF, 1'b1);
    wait_tokens("t7", 5000);
    check("t7_hs", hs_cnt - hsb, 127);

    // Random rounds: either stalled (exact overflow accounting) or free-running
    // with at most FD bytes, which can never overflow.
    for (int r = 0; r < 14; r++) begin
      stall = 1'($urandom_range(0, 1));
      n = stall ? $urandom_range(2, 7) : $urandom_range(1, FD);
      acc = 0; eov = 0; efe = 0;
      ovb = ov_cnt; feb = fe_cnt;
      cmode = stall ? 0 : 1; tick(2);
      for (int f = 0; f < n; f++) begin
        b[7:1] = 7'($urandom_range(0, 5));
        b[0]   = 1'($urandom_range(0, 1));
        bad    = ($urandom_range(0, 5) == 0);
        rxd = 1'b1; tick($urandom_range(0, 3));
        if (bad) begin
          send_frame(b, 1'b0); rxd = 1'b1; tick(); efe++;
        end else begin
          if (!stall || acc < 1 + FD) begin expand(b); acc++; end
          else eov++;
          send_frame(b, 1'b1);
        end
      end
      rxd = 1'b1; tick(3);
      cmode = 1;
      wait_tokens("rnd", 2000);
      check("rnd_ov", ov_cnt - ovb, eov);
      check("rnd_fe", fe_cnt - feb, efe);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/rle_serial_decoder.md
Name: rle_serial_decoder

Overview:
- Downstream stage of the run-length encoder/serializer, on the far end of its serial line.
- Receives the encoder's serial frames on rxd: start bit 0, 8 data bits LSB first, stop bit 1, one bit per clock, idle line at marking 1.
- Decodes each byte as a run: data[7:1] is count, data[0] is colour; a count of 0 means end of line.
- Replays the pixel stream through the team's standard dav_/rfd producer handshake, with a small byte FIFO between the receiver and the pixel emitter.

Parameters:
- FIFO_DEPTH, 4, number of decoded bytes buffered; power of 2, minimum 2.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- rxd  input  1  serial line, synchronous to clock, idle 1.
- colore  output  1  pixel colour (0 bianco, 1 nero).
- endline  output  1  1 marks the end-of-line token.
- dav_  output  1  data valid, active low.
- rfd  input  1  consumer ready-for-data.
- overrun  output  1  one-clock pulse when a decoded byte is dropped because the FIFO is full.
- frame_err  output  1  one-clock pulse when a stop bit is sampled as 0.

Behaviour:
Reset:
- Takes effect at any posedge with reset=1: dav_=1, colore=0, endline=0, overrun=0, frame_err=0.
- FIFO emptied; receiver goes to R_IDLE; emitter goes to E_IDLE.
- This includes reset mid-frame and mid-handshake.

Receiver FSM:
- R_IDLE: an edge sampling rxd=0 is the start bit; go to R_DATA with k=0.
- R_DATA: each of the next 8 edges samples rxd into shift[k], k=0..7; after k=7, go to R_STOP.
- R_STOP: the next edge samples the stop bit.
  - If 1: push shift into the FIFO at that edge and go to R_IDLE. A back-to-back start bit on the very next clock must be accepted.
  - If 0: frame_err=1 for one clock, byte discarded, go to R_RESYNC.
- R_RESYNC: stay until an edge samples rxd=1, then go to R_IDLE.

FIFO:
- Circular buffer of FIFO_DEPTH bytes with an occupancy counter 0..FIFO_DEPTH; no wrap errors.
- Push while full with no pop that cycle: byte dropped, overrun=1 for one clock.
- Push and pop in the same cycle while full: push accepted, occupancy unchanged, no overrun.
- Pop while empty never happens.

Emitter FSM:
- E_IDLE: if the FIFO is non-empty, pop the head (latency: pushed at edge N, popped at edge N+1 if the emitter is idle).
  - Load remaining = data[7:1] and col = data[0].
  - If remaining = 0: token is endline=1, colore=0, one token total.
  - Otherwise: remaining tokens, each endline=0, colore=col.
  - Go to E_SETUP.
- E_SETUP: colore/endline driven, dav_=1. When rfd=1 is sampled, go to E_ACK, with dav_=0 from that edge.
- E_ACK: dav_=0 and colore/endline held stable. When rfd=0 is sampled, go to E_REL, with dav_=1.
- E_REL: dav_=1. When rfd=1 is sampled, decrement remaining (an endline token counts as 1).
  - If remaining > 0: go to E_SETUP.
  - Otherwise: go to E_IDLE.
- colore/endline change only on entry to E_SETUP from E_IDLE.
- Run length 1..127; count 127 yields 127 handshakes.
- A count-0 byte with colour bit 1 (0x01) is also an endline token, emitted with colore=0.
- Receiver and emitter run independently. Bytes keep arriving during long runs and are buffered or dropped per the FIFO rules; data order is preserved.

Test Plan:
1. Reset one clock, rxd=1 for 20 clocks, rfd=1 -> dav_ stays 1, overrun=0, frame_err=0.
2. Frame 0x3D (rxd 0,1,0,1,1,1,1,0,0,1), consumer handshakes normally -> exactly 30 handshakes, each colore=1, endline=0; then dav_ stays 1.
3. Frames 0x00 then 0x01 back to back -> two handshakes, each endline=1, colore=0.
4. Frame 0xFF with stop bit 0, rxd held 0 for 3 more clocks, then 1, then valid frame 0x04 -> frame_err pulses exactly once, no tokens from the bad frame, then 2 tokens colore=0, endline=0.
5. FIFO_DEPTH=4, rfd held 0, six back-to-back frames 0x03, 0x05, 0x07, 0x09, 0x0B, 0x0D -> the first is popped, the next four are buffered, and the sixth gives a one-clock overrun pulse. After rfd resumes: tokens 1,2,3,4,5 of colore=1, total 15 handshakes, in that order.
6. During frame 0x15 (run of 10), assert reset while dav_=0 in E_ACK, with a second frame half-received -> dav_=1 at the next edge, no further tokens. A fresh 0x02 then gives exactly 1 token with colore=0.
